// File: rtl/imem_loader.sv
// Boot loader: validates a header, writes payload words little-endian into
// byte-wide instruction memory, then checks an XOR checksum before releasing the core.
module imem_loader #(
  parameter int          MEM_BYTES = 128,
  parameter int          ADDR_W    = $clog2(MEM_BYTES),
  parameter int          MAX_WORDS = MEM_BYTES / 4,
  parameter logic [15:0] MAGIC     = 16'hB007
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam int KW = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WAIT, S_WR, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     n_q, n_d;
  logic [1:0]        b_q, b_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       acc_q, acc_d;
  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;
  logic [15:0]       hdr_n;
  logic [31:0]       wshift;

  assign xfer  = s_valid && s_ready_q;
  assign hdr_n = s_data[15:0];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    b_d     = b_q;
    word_d  = word_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          err_d   = 1'b0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (s_data[31:16] != MAGIC || 32'(hdr_n) > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (hdr_n == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_WAIT;
            n_d     = hdr_n[KW-1:0];
            k_d     = '0;
          end
        end
      end
      S_WAIT: begin
        if (xfer) begin
          word_d  = s_data;
          acc_d   = acc_q ^ s_data;
          b_d     = 2'd0;
          state_d = S_WR;
        end
      end
      S_WR: begin
        b_d = b_q + 2'd1;
        if (b_q == 2'd3) begin
          k_d     = k_q + KW'(1);
          state_d = (k_d == n_q) ? S_CSUM : S_WAIT;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (s_data == acc_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    wshift      = word_d >> {b_d, 3'b000};
    s_ready_d   = state_d inside {S_HDR, S_WAIT, S_CSUM};
    mem_we_d    = state_d == S_WR;
    mem_addr_d  = mem_we_d ? {k_d[ADDR_W-3:0], b_d} : '0;
    mem_wdata_d = mem_we_d ? wshift[7:0] : '0;
    busy_d      = state_d inside {S_HDR, S_WAIT, S_WR, S_CSUM};
    done_d      = state_q == S_CSUM && state_d == S_DONE;
    core_rst_d  = state_d != S_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      word_q      <= '0;
      acc_q       <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      b_q         <= b_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_rst     = core_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = k_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a session-level reference model queues
// expected byte writes and outcomes; a monitor checks them as they appear.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  words_loaded;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_evt[$];
  int  vectors = 0;
  int  errs = 0;
  logic err_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    vectors++;
    errs++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Monitor: compares every write / completion against the scoreboard.
  initial begin
    wr_t e;
    int  ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we) begin
          chk("s_ready_in_wr", 32'(s_ready), 0);
          if (exp_wr.size() == 0) flag("unexpected_write");
          else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.a));
            chk("wr_data", 32'(mem_wdata), 32'(e.d));
          end
        end
        if (done || (err && !err_prev)) begin
          if (exp_evt.size() == 0) flag("unexpected_outcome");
          else begin
            ev = exp_evt.pop_front();
            chk("outcome", done ? 1 : 2, 32'(ev));
          end
        end
      end
      err_prev = err;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] w, input int gap_max);
    int n;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("s_ready_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  // Reference model at session level: decides what the stream means,
  // queues expected writes/outcome, drives only the words that get consumed.
  task automatic session(input logic [31:0] ws[$], input int gap_max);
    logic [31:0] acc;
    int          n;
    int          used;
    bit          ok;
    int          exp_wl;
    int          t;
    n   = int'(ws[0][15:0]);
    acc = '0;
    if (ws[0][31:16] != 16'hB007 || n > 32) begin
      used = 1; ok = 0; exp_wl = 0;
    end else begin
      for (int i = 1; i <= n; i++) begin
        acc = acc ^ ws[i];
        for (int b = 0; b < 4; b++)
          exp_wr.push_back('{a: 7'(4 * (i - 1) + b), d: 8'(ws[i] >> (8 * b))});
      end
      used = n + 2; ok = (ws[n + 1] == acc); exp_wl = n;
    end
    exp_evt.push_back(ok ? 1 : 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("err_cleared", 32'(err), 0);
    for (int i = 0; i < used; i++) send(ws[i], gap_max);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("busy_end", 32'(busy), 0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("evt_queue_empty", 32'(exp_evt.size()), 0);
    chk("err_final", 32'(err), ok ? 0 : 1);
    chk("core_rst_final", 32'(core_rst), ok ? 0 : 1);
    chk("words_loaded", 32'(words_loaded), 32'(exp_wl));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("s_ready_idle", 32'(s_ready), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_rst"}, 32'(core_rst), 1);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_words"}, 32'(words_loaded), 0);
  endtask

  initial begin
    logic [31:0] good[$];
    logic [31:0] ws[$];
    logic [31:0] acc;
    int n;
    int t;
    good = '{32'hB0070002, 32'h8C010004, 32'h00221820, 32'h8C231824};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    session(good, 0);
    session('{32'hDEAD0001}, 0);
    session('{32'hB0070021}, 0);
    session('{32'hB0070001, 32'h11111111, 32'h00000000}, 0);
    session('{32'hB0070000, 32'h00000000}, 0);
    session(good, 4);

    // Largest payload: last byte lands at address 127.
    ws = '{32'hB0070020};
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      ws.push_back($urandom);
      acc = acc ^ ws[$];
    end
    ws.push_back(acc);
    session(ws, 1);

    // Reset during byte 2 of the first payload word.
    exp_wr.push_back('{a: 7'd0, d: 8'h04});
    exp_wr.push_back('{a: 7'd1, d: 8'h00});
    exp_wr.push_back('{a: 7'd2, d: 8'h01});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(good[0], 0);
    send(good[1], 0);
    t = 0;
    while (!(mem_we && mem_addr == 7'd2) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("reach_byte2", 32'(mem_addr), 2);
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle", 32'(busy), 0);
    chk("midrst_wr_empty", 32'(exp_wr.size()), 0);
    session(good, 2);

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      t = $urandom_range(0, 19);
      if (t == 0) ws = '{{16'($urandom), 16'd1}};
      else if (t == 1) ws = '{{16'hB007, 16'($urandom_range(33, 65535))}};
      else begin
        n = $urandom_range(0, 6);
        ws = '{{16'hB007, 16'(n)}};
        acc = '0;
        for (int i = 0; i < n; i++) begin
          ws.push_back($urandom);
          acc = acc ^ ws[$];
        end
        if ($urandom_range(0, 3) == 0) acc = acc ^ (32'd1 << $urandom_range(0, 31));
        ws.push_back(acc);
      end
      if (ws[0][31:16] == 16'hB007 && ws.size() == 1 && ws[0][15:0] <= 16'd32)
        ws[0][31:16] = 16'hBAD0;
      session(ws, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
